// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the timer_device countdown timer.
package timer_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PRESET  = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: one-cycle tick every DIV clocks; clr holds the phase at 0.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer driving one CP0 HWInt line.
// Define TIMER_PRESCALE_EN to decrement only every PRESC_DIV clocks.
module timer_device
  import timer_pkg::*;
#(
  parameter int COUNT_W   = 32,
  parameter int PRESC_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);
  state_e state_q, state_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic flag_q, flag_d;
  logic tick, wr_ctrl, en, reload;
`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(.DIV(PRESC_DIV)) u_presc (
    .clk(clk),
    .reset(reset),
    .clr(state_q == S_IDLE || state_q == S_LOAD),
    .tick(tick)
  );
`else
  logic unused_presc;
  assign unused_presc = PRESC_DIV != 0;
  assign tick = 1'b1;
`endif
  assign wr_ctrl = WE && Addr == ADDR_CTRL;
  assign en      = ctrl_q[CTRL_EN];
  assign reload  = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  assign IRQ     = ctrl_q[CTRL_IM] & flag_q;
  always_comb begin
    Dout = Addr == ADDR_CTRL   ? {28'b0, ctrl_q} :
           Addr == ADDR_PRESET ? 32'(preset_q) :
           Addr == ADDR_COUNT  ? 32'(count_q) : '0;
  end
  // Expiry sets the flag after the CTRL-write clear, so an ack on that edge loses nothing.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = wr_ctrl ? Din[3:0] : ctrl_q;
    preset_d = (WE && Addr == ADDR_PRESET) ? Din[COUNT_W-1:0] : preset_q;
    count_d  = count_q;
    flag_d   = wr_ctrl ? 1'b0 : flag_q;
    case (state_q)
      S_IDLE: state_d = en ? S_LOAD : S_IDLE;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) state_d = S_IDLE;
        else if (tick) begin
          if (count_q > COUNT_W'(1)) count_d = count_q - COUNT_W'(1);
          else begin
            count_d = '0;
            flag_d  = 1'b1;
            state_d = S_INT;
          end
        end
      end
      S_INT: begin
        if (reload) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          if (!wr_ctrl) ctrl_d[CTRL_EN] = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed register-level checks of timer_device via a read scoreboard.
module tb_timer_device;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        rd_stb = 1'b0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    string       n;
    logic [31:0] d;
    logic        i;
  } exp_t;
  exp_t sb[$];

  timer_device dut (
    .clk(clk),
    .reset(reset),
    .Addr(Addr),
    .WE(WE),
    .Din(Din),
    .Dout(Dout),
    .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rd_stb) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: read strobe with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (Dout !== e.d || IRQ !== e.i) begin
          failures++;
          $display("FAIL %s: got Dout=%h IRQ=%b, expected Dout=%h IRQ=%b", e.n, Dout, IRQ, e.d, e.i);
        end
      end
    end
  end

  // Observes the state left by the last edge, then lets one more edge pass.
  task automatic chk(input string n, input logic [1:0] a, input logic [31:0] d, input logic i);
    Addr = a;
    rd_stb = 1'b1;
    sb.push_back('{n, d, i});
    @(negedge clk);
    @(posedge clk);
    #1;
    rd_stb = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din = d;
    WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rst(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] os_cnt [0:7];
    int j;
    os_cnt = '{0, 0, 5, 4, 3, 2, 1, 0};
    rst(2);
    for (int a = 0; a < 4; a++) chk($sformatf("reset_addr%0d", a), 2'(a), 32'd0, 1'b0);
    wr(2'd2, 32'h55);
    wr(2'd3, 32'h66);
    chk("ignored_wr_count", 2'd2, 32'd0, 1'b0);
    chk("ignored_wr_rsvd", 2'd3, 32'd0, 1'b0);

    // one-shot, PRESET=5, IRQ from E7
    rst(1);
    wr(2'd1, 32'd5);
    chk("preset_rd", 2'd1, 32'd5, 1'b0);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 8; k++) chk($sformatf("os_count_e%0d", k), 2'd2, os_cnt[k], k == 7);
    chk("os_ctrl_autoclr", 2'd0, 32'h8, 1'b1);
    chk("os_irq_held", 2'd0, 32'h8, 1'b1);
    wr(2'd0, 32'h8);
    chk("os_ack", 2'd0, 32'h8, 1'b0);

    // auto-reload, PRESET=3, period 5
    rst(1);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 0; k <= 20; k++) begin
      j = (k - 2) % 5;
      chk($sformatf("ar_e%0d", k), 2'd2, (k < 2 || j >= 3) ? 32'd0 : 32'(3 - j), k >= 5 && (k - 5) % 5 == 0);
    end

    // masked expiry
    rst(1);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 5; k++) chk($sformatf("mask_e%0d", k), 2'd2, k == 2 ? 32'd2 : k == 3 ? 32'd1 : 32'd0, 1'b0);
    chk("mask_ctrl", 2'd0, 32'h0, 1'b0);
    wr(2'd0, 32'h8);
    chk("mask_ack", 2'd0, 32'h8, 1'b0);

    // pause freezes count, re-enable reloads
    rst(1);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 4; k++) chk($sformatf("pause_e%0d", k), 2'd2, k < 2 ? 32'd0 : 32'(12 - k), 1'b0);
    wr(2'd0, 32'h8);
    for (int k = 5; k < 8; k++) chk($sformatf("frozen_e%0d", k), 2'd2, 32'd7, 1'b0);
    wr(2'd0, 32'h1);
    chk("reen_idle", 2'd2, 32'd7, 1'b0);
    chk("reen_load", 2'd2, 32'd7, 1'b0);
    chk("reen_restart", 2'd2, 32'd10, 1'b0);

    // CTRL write on the expiry edge keeps the flag
    rst(1);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 3; k++) chk($sformatf("exp_e%0d", k), 2'd2, k == 2 ? 32'd2 : 32'd0, 1'b0);
    wr(2'd0, 32'h9);
    chk("exp_wr_flag_kept", 2'd0, 32'h9, 1'b1);
    chk("exp_int_leave", 2'd0, 32'h8, 1'b1);

    // PRESET=0 and CTRL write on the edge leaving INT
    rst(1);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 3; k++) chk($sformatf("p0_e%0d", k), 2'd0, 32'h1, 1'b0);
    wr(2'd0, 32'h9);
    for (int k = 4; k < 7; k++) chk($sformatf("leave_int_e%0d", k), 2'd0, 32'h9, 1'b0);
    chk("p0_reexpire", 2'd0, 32'h9, 1'b1);
    chk("p0_oneshot_clr", 2'd0, 32'h8, 1'b1);

    // mode 1x acts as one-shot
    rst(1);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hD);
    for (int k = 0; k < 3; k++) chk($sformatf("m10_e%0d", k), 2'd0, 32'hD, 1'b0);
    chk("m10_flag", 2'd0, 32'hD, 1'b1);
    chk("m10_autoclr", 2'd0, 32'hC, 1'b1);
    chk("m10_stays_idle", 2'd2, 32'd0, 1'b1);

    // reset mid-count
    rst(1);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 4; k++) chk($sformatf("rmid_e%0d", k), 2'd2, os_cnt[k], 1'b0);
    rst(1);
    for (int a = 0; a < 4; a++) chk($sformatf("rmid_after_addr%0d", a), 2'(a), 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
